// File: rtl/core_pkg.sv
// Shared core-wide types and constants used by the fetch front end and pipeline registers.
package core_pkg;

   localparam int CORE_XLEN = 32;

   // Bubble the IF/ID register inserts when the front end is flushed
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [CORE_XLEN-1:0] pc;
      logic [31:0]          inst;
      logic                 filled;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction prefetch queue: issues sequential fetches, buffers responses for decode,
// and on a redirect flushes every entry while discarding responses still in flight.
module fetch_queue
   import core_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter int               DEPTH    = 4,
   parameter int               MAX_OUT  = 2,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       imem_req,
   output logic [XLEN-1:0]            imem_addr,
   input  logic                       imem_gnt,
   input  logic                       imem_rvalid,
   input  logic [31:0]                imem_rdata,
   output logic                       dec_valid,
   output logic [XLEN-1:0]            dec_pc,
   output logic [31:0]                dec_inst,
   input  logic                       dec_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int OUT_W = CNT_W + 1;

   fq_entry_t          entries [DEPTH];
   logic [XLEN-1:0]    fetch_pc;
   logic [PTR_W-1:0]   alloc_ptr;
   logic [PTR_W-1:0]   fill_ptr;
   logic [PTR_W-1:0]   head_ptr;
   logic [CNT_W-1:0]   occ;
   logic [CNT_W-1:0]   pend;
   logic [CNT_W-1:0]   drop_cnt;
   logic [OUT_W-1:0]   outstanding;
   logic [OUT_W-1:0]   redirect_drop;
   logic               accept;
   logic               fill_en;
   logic               drop_en;
   logic               pop;

   // Requests still owed a response, counting those that will be thrown away
   assign outstanding   = OUT_W'(pend) + OUT_W'(drop_cnt);
   assign redirect_drop = outstanding - OUT_W'(imem_rvalid && (outstanding != '0));

   assign imem_req  = rst && !redirect && (occ < CNT_W'(DEPTH)) && (outstanding < OUT_W'(MAX_OUT));
   assign imem_addr = fetch_pc;
   assign accept    = imem_req && imem_gnt;
   assign drop_en   = imem_rvalid && (drop_cnt != '0);
   assign fill_en   = imem_rvalid && (drop_cnt == '0) && (pend != '0);

   assign dec_valid = entries[head_ptr].filled;
   assign dec_pc    = entries[head_ptr].pc;
   assign dec_inst  = entries[head_ptr].inst;
   assign count     = occ;
   assign pop       = dec_valid && dec_ready && !redirect;

   // Accept, fill and pop never touch the same slot in one cycle, so all three may update together
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         fetch_pc  <= RESET_PC;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         occ       <= '0;
         pend      <= '0;
         drop_cnt  <= '0;
      end else if (redirect) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         fetch_pc  <= redirect_pc & ~XLEN'(3);
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         occ       <= '0;
         pend      <= '0;
         drop_cnt  <= CNT_W'(redirect_drop);
      end else begin
         if (accept) begin
            entries[alloc_ptr] <= '{pc: fetch_pc, inst: '0, filled: 1'b0};
            alloc_ptr          <= alloc_ptr + PTR_W'(1);
            fetch_pc           <= fetch_pc + XLEN'(4);
         end
         if (fill_en) begin
            entries[fill_ptr].inst   <= imem_rdata;
            entries[fill_ptr].filled <= 1'b1;
            fill_ptr                 <= fill_ptr + PTR_W'(1);
         end
         if (pop) begin
            entries[head_ptr].filled <= 1'b0;
            head_ptr                 <= head_ptr + PTR_W'(1);
         end
         if (drop_en) begin
            drop_cnt <= drop_cnt - CNT_W'(1);
         end
         occ  <= occ + CNT_W'(accept) - CNT_W'(pop);
         pend <= pend + CNT_W'(accept) - CNT_W'(fill_en);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a variable-latency memory model feeds the queue and
// an in-order reference of expected fetches is compared against what decode receives.
module tb_fetch_queue;
   import core_pkg::*;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          CNT_W    = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              redirect = 1'b0;
   logic [XLEN-1:0]   redirect_pc = '0;
   logic              imem_req;
   logic [XLEN-1:0]   imem_addr;
   logic              imem_gnt = 1'b0;
   logic              imem_rvalid = 1'b0;
   logic [31:0]       imem_rdata = '0;
   logic              dec_valid;
   logic [XLEN-1:0]   dec_pc;
   logic [31:0]       dec_inst;
   logic              dec_ready = 1'b0;
   logic [CNT_W-1:0]  count;

   fetch_queue #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .MAX_OUT  (MAX_OUT),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .dec_valid   (dec_valid),
      .dec_pc      (dec_pc),
      .dec_inst    (dec_inst),
      .dec_ready   (dec_ready),
      .count       (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      bit          filled;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } flight_t;

   exp_t        exp_q[$];
   flight_t     flight_q[$];
   int          checks = 0;
   int          fails = 0;
   int          pops = 0;
   int          cyc = 0;
   int          last_due = 0;
   int          epoch = 0;
   logic [31:0] model_pc = RESET_PC;

   int          lat_min = 1;
   int          lat_max = 1;
   int          gnt_pct = 100;
   int          rdy_pct = 100;
   int          redir_pct = 0;
   bit          force_redir = 1'b0;
   bit          redir_on_coincide = 1'b0;
   logic [31:0] force_target = '0;

   // Odd multiplier keeps every aligned address mapped to a distinct word
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // One clock cycle: check registered state, drive inputs, then advance the reference model
   task automatic applyStimulus();
      bit          do_redir;
      bit          exp_req;
      bit          marked;
      logic [31:0] target;
      flight_t     fl;
      @(negedge clk);
      cyc++;
      checkOutput("count", 32'(count), 32'(exp_q.size()));
      checkOutput("dec_valid", 32'(dec_valid), 32'(exp_q.size() > 0 && exp_q[0].filled));
      dec_ready = ($urandom_range(99) < rdy_pct);
      imem_gnt  = ($urandom_range(99) < gnt_pct);
      if (flight_q.size() > 0 && flight_q[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(flight_q[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      do_redir = 1'b0;
      target   = $urandom;
      if (force_redir) begin
         do_redir    = 1'b1;
         target      = force_target;
         force_redir = 1'b0;
      end else if (redir_on_coincide && imem_rvalid && dec_valid && dec_ready) begin
         do_redir          = 1'b1;
         target            = force_target;
         redir_on_coincide = 1'b0;
      end else if ($urandom_range(99) < redir_pct) begin
         do_redir = 1'b1;
      end
      redirect    = do_redir;
      redirect_pc = target;
      #1;
      exp_req = !do_redir && (exp_q.size() < DEPTH) && (flight_q.size() < MAX_OUT);
      checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
      if (imem_req && imem_gnt) begin
         checkOutput("imem_addr", imem_addr, model_pc);
         exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc), filled: 1'b0});
         fl.addr  = imem_addr;
         fl.due   = (cyc + int'($urandom_range(lat_max, lat_min)) > last_due + 1) ?
                    cyc + int'($urandom_range(lat_max, lat_min)) : last_due + 1;
         if (fl.due <= cyc) fl.due = cyc + 1;
         fl.epoch = epoch;
         last_due = fl.due;
         flight_q.push_back(fl);
         model_pc = model_pc + 32'd4;
      end
      if (imem_rvalid) begin
         fl = flight_q.pop_front();
         if (!do_redir && fl.epoch == epoch) begin
            marked = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
               if (!marked && !exp_q[i].filled) begin
                  exp_q[i].filled = 1'b1;
                  marked = 1'b1;
               end
            end
         end
      end
      if (do_redir) begin
         exp_q.delete();
         model_pc = target & ~32'd3;
         epoch++;
      end
   endtask

   // Asserts reset mid-cycle, expects every output to clear at once, then releases after a posedge
   task automatic do_reset();
      @(negedge clk);
      #3;
      rst         = 1'b0;
      redirect    = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      dec_ready   = 1'b0;
      #1;
      checkOutput("rst_dec_valid", 32'(dec_valid), 32'd0);
      checkOutput("rst_dec_pc", dec_pc, 32'd0);
      checkOutput("rst_dec_inst", dec_inst, 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_imem_addr", imem_addr, RESET_PC);
      exp_q.delete();
      flight_q.delete();
      epoch++;
      model_pc = RESET_PC;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Monitor: every accepted decode transfer must match the oldest expected fetch
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst && dec_valid && dec_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL pop_unexpected: got pc 0x%08h, expected no transfer", dec_pc);
            end else begin
               e = exp_q.pop_front();
               checkOutput("dec_pc", dec_pc, e.pc);
               checkOutput("dec_inst", dec_inst, e.inst);
               pops++;
            end
         end
      end
   end

   initial begin
      int  base;
      bit  found;

      // Back-to-back fetches from reset with single-cycle memory
      do_reset();
      applyStimulus();
      applyStimulus();
      checkOutput("first_valid_c1", 32'(dec_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("first_valid_c2", 32'(dec_valid), 32'd1);
      checkOutput("first_pc_c2", dec_pc, 32'h0);
      checkOutput("first_inst_c2", dec_inst, mem_word(32'h0));
      repeat (18) applyStimulus();

      // Decode stalled: queue fills to DEPTH, then drains one per cycle
      do_reset();
      rdy_pct = 0;
      repeat (10) applyStimulus();
      checkOutput("stall_count", 32'(count), 32'(DEPTH));
      checkOutput("stall_req", 32'(imem_req), 32'd0);
      rdy_pct = 100;
      base = pops;
      repeat (4) applyStimulus();
      #2;
      checkOutput("drain_pops", 32'(pops - base), 32'd4);
      repeat (10) applyStimulus();

      // Three-cycle memory with random grant and backpressure
      lat_min = 3;
      lat_max = 3;
      gnt_pct = 80;
      rdy_pct = 70;
      base = pops;
      repeat (80) applyStimulus();
      checkOutput("l3_throughput", 32'(pops - base >= 10), 32'd1);

      // Redirect with two requests in flight to an unaligned target
      gnt_pct = 100;
      rdy_pct = 100;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (flight_q.size() == MAX_OUT) found = 1'b1;
         else applyStimulus();
      end
      checkOutput("two_in_flight", 32'(found), 32'd1);
      force_target = 32'h0000_0103;
      force_redir  = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("redir_addr", imem_addr, 32'h0000_0100);
      checkOutput("redir_count", 32'(count), 32'd0);
      repeat (15) applyStimulus();

      // Redirect in the same cycle as a response and a ready head entry
      lat_min = 1;
      lat_max = 1;
      repeat (5) applyStimulus();
      force_target      = 32'h0000_0200;
      redir_on_coincide = 1'b1;
      for (int i = 0; i < 20 && redir_on_coincide; i++) applyStimulus();
      checkOutput("coincide_hit", 32'(redir_on_coincide), 32'd0);
      redir_on_coincide = 1'b0;
      repeat (10) applyStimulus();

      // Random soak with variable latency and random redirects
      lat_max   = 4;
      gnt_pct   = 70;
      rdy_pct   = 70;
      redir_pct = 3;
      repeat (400) applyStimulus();

      // Reset in the middle of traffic, then resume cleanly
      do_reset();
      lat_max   = 1;
      gnt_pct   = 100;
      rdy_pct   = 100;
      redir_pct = 0;
      repeat (20) applyStimulus();

      @(negedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
